// File: rtl/mux4_rr_arbiter_if.sv
// Request/grant bundle between four requesters and the round-robin mux arbiter.
// The master side drives requests and data; the slave side returns grant, select and output.
interface mux4_rr_arbiter_if #(
    parameter int DW = 8
);
    logic [3:0]      req;
    logic [4*DW-1:0] in_bus;
    logic [3:0]      gnt;
    logic [1:0]      sel;
    logic            y_valid;
    logic [DW-1:0]   y;

    modport master (
        output req,
        output in_bus,
        input  gnt,
        input  sel,
        input  y_valid,
        input  y
    );

    modport slave (
        input  req,
        input  in_bus,
        output gnt,
        output sel,
        output y_valid,
        output y
    );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter owning the select of a shared 4:1 data mux.
// Optional macro ARB_TIMEOUT_EN bounds a contended grant to HOLD_MAX cycles.
module mux4_rr_arbiter #(
    parameter int DW       = 8,
    parameter int HOLD_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    mux4_rr_arbiter_if.slave  bus
);

    if (HOLD_MAX < 2) begin : g_hold_chk
        $error("HOLD_MAX must be at least 2");
    end

    typedef enum logic {IDLE, GRANT} state_t;

    state_t      state, state_n;
    logic [3:0]  gnt_r, gnt_n;
    logic [1:0]  sel_r, sel_n;
    logic [1:0]  ptr, ptr_n;
    logic [3:0]  others;
    logic [DW-1:0] words [4];

`ifdef ARB_TIMEOUT_EN
    localparam int HW = $clog2(HOLD_MAX + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MAX - 1);
    logic [HW-1:0] hold_cnt, hold_n;
`endif

    // First set bit of r walking start, start+1, ... with 2-bit wraparound.
    function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] start);
        logic [1:0] idx;
        pick = start;
        for (int i = 3; i >= 0; i--) begin
            idx = start + 2'(i);
            if (r[idx]) pick = idx;
        end
    endfunction

    always_comb begin
        state_n = state;
        gnt_n   = gnt_r;
        sel_n   = sel_r;
        ptr_n   = ptr;
        others  = bus.req & ~(4'b0001 << sel_r);
`ifdef ARB_TIMEOUT_EN
        hold_n  = hold_cnt;
`endif
        case (state)
            IDLE: begin
                if (|bus.req) begin
                    sel_n   = pick(bus.req, ptr);
                    gnt_n   = 4'b0001 << sel_n;
                    state_n = GRANT;
`ifdef ARB_TIMEOUT_EN
                    hold_n  = '0;
`endif
                end
            end
            GRANT: begin
                if (!bus.req[sel_r]) begin
                    ptr_n = sel_r + 2'd1;
`ifdef ARB_TIMEOUT_EN
                    hold_n = '0;
`endif
                    if (|bus.req) begin
                        sel_n = pick(bus.req, sel_r + 2'd1);
                        gnt_n = 4'b0001 << sel_n;
                    end else begin
                        gnt_n   = 4'b0000;
                        state_n = IDLE;
                    end
                end
`ifdef ARB_TIMEOUT_EN
                // Owner still requesting: at the cycle limit yield to any waiter.
                else if (hold_cnt == HOLD_LAST) begin
                    hold_n = '0;
                    if (|others) begin
                        sel_n = pick(others, sel_r + 2'd1);
                        gnt_n = 4'b0001 << sel_n;
                        ptr_n = sel_r + 2'd1;
                    end
                end else begin
                    hold_n = hold_cnt + 1'b1;
                end
`endif
            end
            default: begin
                state_n = IDLE;
                gnt_n   = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            gnt_r <= 4'b0000;
            sel_r <= 2'd0;
            ptr   <= 2'd0;
`ifdef ARB_TIMEOUT_EN
            hold_cnt <= '0;
`endif
        end else begin
            state <= state_n;
            gnt_r <= gnt_n;
            sel_r <= sel_n;
            ptr   <= ptr_n;
`ifdef ARB_TIMEOUT_EN
            hold_cnt <= hold_n;
`endif
        end
    end

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            words[k] = bus.in_bus[k*DW +: DW];
        end
    end

    assign bus.gnt     = gnt_r;
    assign bus.sel     = sel_r;
    assign bus.y_valid = |gnt_r;
    assign bus.y       = bus.y_valid ? words[sel_r] : '0;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench for mux4_rr_arbiter: the driver queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_mux4_rr_arbiter;

    localparam int DW = 8;
    localparam int HM = 4;

    typedef struct {
        string          name;
        logic [3:0]     gnt;
        logic [1:0]     sel;
        logic           chk_sel;
        logic [DW-1:0]  y;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    localparam logic [4*DW-1:0] BUS_A = {8'h44, 8'hA5, 8'h22, 8'h11};
    localparam logic [4*DW-1:0] BUS_B = {8'h44, 8'h3C, 8'h22, 8'h11};

    mux4_rr_arbiter_if #(.DW(DW)) bus ();

    mux4_rr_arbiter #(.DW(DW), .HOLD_MAX(HM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req_v, $time);
        end
    endtask

    function automatic logic [DW-1:0] word_of(input logic [4*DW-1:0] b, input logic [1:0] k);
        logic [DW-1:0] w [4];
        for (int i = 0; i < 4; i++) w[i] = b[i*DW +: DW];
        return w[k];
    endfunction

    task automatic push_exp(input string nm, input logic [3:0] eg, input logic [1:0] es,
                            input logic cs, input logic [4*DW-1:0] b);
        exp_t e;
        e.name    = nm;
        e.gnt     = eg;
        e.sel     = es;
        e.chk_sel = cs;
        e.y       = (eg != 4'b0000) ? word_of(b, es) : '0;
        sb.push_back(e);
    endtask

    // Apply inputs just after an edge; expectation is what the negedge of this cycle shows.
    task automatic step(input string nm, input logic r, input logic [3:0] rq,
                        input logic [4*DW-1:0] b, input logic [3:0] eg, input logic [1:0] es);
        @(posedge clk);
        #1;
        rst        = r;
        bus.req    = rq;
        bus.in_bus = b;
        push_exp(nm, eg, es, (eg != 4'b0000) || r, b);
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check({e.name, ".gnt"}, 32'(bus.gnt), 32'(e.gnt));
            check({e.name, ".y_valid"}, 32'(bus.y_valid), 32'(|e.gnt));
            check({e.name, ".y"}, 32'(bus.y), 32'(e.y));
            if (e.chk_sel) check({e.name, ".sel"}, 32'(bus.sel), 32'(e.sel));
        end
    end

    initial begin
        logic [3:0] eg;
        bus.req    = 4'b1111;
        bus.in_bus = BUS_A;

        // T1: reset holds everything at zero despite requests; first grant goes to 0.
        step("t1_rst",     1'b1, 4'b1111, BUS_A, 4'b0000, 2'd0);
        step("t1_rel",     1'b0, 4'b1111, BUS_A, 4'b0000, 2'd0);
        step("t1_first",   1'b0, 4'b0000, BUS_A, 4'b0001, 2'd0);
        step("t1_idle",    1'b0, 4'b0100, BUS_A, 4'b0000, 2'd0);

        // T2: single requester 2, y follows in_bus combinationally.
        step("t2_gnt",     1'b0, 4'b0100, BUS_A, 4'b0100, 2'd2);
        step("t2_track",   1'b0, 4'b0100, BUS_B, 4'b0100, 2'd2);
        step("t2_hold",    1'b0, 4'b0000, BUS_A, 4'b0100, 2'd2);
        step("t2_idle",    1'b0, 4'b1000, BUS_A, 4'b0000, 2'd0);

        // T4: owner 3 releases while only requester 0 waits.
        step("t4_own3",    1'b0, 4'b0001, BUS_A, 4'b1000, 2'd3);
        step("t4_wrap",    1'b0, 4'b1111, BUS_A, 4'b0001, 2'd0);

        // T3: all request, each owner drops after two grant cycles.
        step("t3_0b",      1'b0, 4'b1110, BUS_A, 4'b0001, 2'd0);
        step("t3_1a",      1'b0, 4'b1111, BUS_A, 4'b0010, 2'd1);
        step("t3_1b",      1'b0, 4'b1101, BUS_A, 4'b0010, 2'd1);
        step("t3_2a",      1'b0, 4'b1111, BUS_A, 4'b0100, 2'd2);
        step("t3_2b",      1'b0, 4'b1011, BUS_A, 4'b0100, 2'd2);
        step("t3_3a",      1'b0, 4'b1111, BUS_A, 4'b1000, 2'd3);
        step("t3_3b",      1'b0, 4'b0111, BUS_A, 4'b1000, 2'd3);

        // T5: requesters 0 and 1 held continuously.
        for (int i = 0; i < 13; i++) begin
`ifdef ARB_TIMEOUT_EN
            eg = (((i / HM) % 2) == 0) ? 4'b0001 : 4'b0010;
`else
            eg = 4'b0001;
`endif
            step($sformatf("t5_c%0d", i), 1'b0, 4'b0011, BUS_A, eg, (eg == 4'b0010) ? 2'd1 : 2'd0);
        end

        // T6: move the grant to 2, then pulse reset between edges.
`ifdef ARB_TIMEOUT_EN
        step("t6_pre",     1'b0, 4'b0100, BUS_A, 4'b0010, 2'd1);
`else
        step("t6_pre",     1'b0, 4'b0100, BUS_A, 4'b0001, 2'd0);
`endif
        step("t6_own2",    1'b0, 4'b0100, BUS_A, 4'b0100, 2'd2);
        @(posedge clk);
        #2;
        rst = 1'b1;
        push_exp("t6_async", 4'b0000, 2'd0, 1'b1, BUS_A);
        @(negedge clk);
        #1;
        rst     = 1'b0;
        bus.req = 4'b0110;
        step("t6_after",   1'b0, 4'b0000, BUS_A, 4'b0010, 2'd1);
        step("t6_idle",    1'b0, 4'b0000, BUS_A, 4'b0000, 2'd0);

        for (int n = 0; n < 5 && sb.size() != 0; n++) @(posedge clk);
        #7;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
